adam_dmi_cmd_engine: RTL and testbench
======================================

// Module: adam_dmi_cmd_engine
// PURPOSE
// Hardware sequencer for RISC-V Debug Module Interface (DMI) transactions, the synthesizable successor of the
// JTAG-bench DMI read/write/poll tasks. Accepts read/write/poll commands, drives a DMI request/response port toward
// the DM, retries on busy, and waits between accesses. Poll compares masked read data until match or timeout.
// Sits between a debug host (ROM sequencer or AXI-Lite shim) and the debug module in the lsdom.
// PARAMETERS
// ABITS        7     DMI address width
// DW           32    DMI data width
// IDLE         1     min idle cycles between a response and the next DMI request (0 allowed)
// MAX_RETRY    8     busy retries per access before ERR_BUSY (0 = no retry)
// POLL_TMO     1024  max poll reads before TIMEOUT (>=1)
// PORTS
// seq.clk        in   1      clock (ADAM_SEQ); all logic on rising edge
// seq.rst        in   1      synchronous, active-high reset
// cmd_valid      in   1      command handshake
// cmd_ready      out  1      engine idle, can take command
// cmd_op         in   2      cmd_op_t: NOP=0, READ=1, WRITE=2, POLL=3
// cmd_addr       in   ABITS  DM register address
// cmd_data       in   DW     write data / poll expected value
// cmd_mask       in   DW     poll compare mask (ignored otherwise)
// rsp_valid      out  1      result handshake
// rsp_ready      in   1      host accepts result
// rsp_data       out  DW     last read data (0 for WRITE/NOP)
// rsp_status     out  2      rsp_status_t: OK=0, ERR_FAIL=1, ERR_BUSY=2, TIMEOUT=3
// rsp_polls      out  $clog2(POLL_TMO+1)  poll reads issued
// dmi_req_valid  out  1      DMI request handshake
// dmi_req_ready  in   1
// dmi_req_addr   out  ABITS
// dmi_req_data   out  DW
// dmi_req_op     out  2      1=read, 2=write
// dmi_rsp_valid  in   1      DMI response handshake
// dmi_rsp_ready  out  1      high only in WAIT
// dmi_rsp_data   in   DW
// dmi_rsp_op     in   2      0=success, 2=failed, 3=busy (1 treated as failed)
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=1; rsp_valid=0; dmi_req_valid=0; dmi_rsp_ready=0; rsp_data=0;
//   rsp_status=OK; rsp_polls=0; all counters 0. A reset mid-operation discards the command and any
//   outstanding DMI response; the DMI side is reset together.
// - States: IDLE -> ISSUE -> WAIT -> (GAP) -> ISSUE | RESP -> IDLE.
// - IDLE: cmd_ready=1. On cmd_valid, latch op/addr/data/mask and clear counters. NOP goes straight to RESP/OK.
// - ISSUE: dmi_req_valid=1; addr/data/op are stable until dmi_req_ready. POLL issues a read. Then go to WAIT.
// - WAIT: dmi_rsp_ready=1. On dmi_rsp_valid:
//   - busy: retry++; if retry>MAX_RETRY -> RESP/ERR_BUSY, else GAP.
//   - failed: RESP/ERR_FAIL.
//   - success, READ/WRITE: RESP/OK, with rsp_data = read data.
//   - success, POLL: polls++; if (rd & mask)==(data & mask) -> RESP/OK; elif polls==POLL_TMO -> RESP/TIMEOUT
//     (rsp_data = last read); else GAP with retry cleared.
// - GAP: hold IDLE cycles, then ISSUE. IDLE=0 bypasses GAP (ISSUE the next cycle).
// - RESP: rsp_valid=1 with fields stable until rsp_ready; then IDLE. cmd_ready=1 the cycle after the handshake.
// - Command-to-first-request latency 1 cycle. Only one DMI access outstanding ever.
// - Counters saturate and never wrap. Width checks: ABITS>=1, POLL_TMO>=1 (elaboration assertion).
// - A dmi_rsp_valid outside WAIT is a protocol violation: flagged by assertion, otherwise ignored.
// STRUCTURE
// - adam_dmi_pkg: cmd_op_t, rsp_status_t, dmi_op_t enums; DMI_OP_* and DM register address constants
//   (DMCONTROL=7'h10, DMSTATUS=7'h11, bit indices haltreq=31, resumereq=30, allhalted=9, allresumeack=17).
// - Single FSM module, no sub-modules; the gap/retry/poll counters are inline.
// TESTING
// - WRITE 0x10 data 0x1 with a DM stub answering success -> one dmi write, rsp OK, rsp_data 0, 1-cycle issue latency.
// - READ 0x11 with the stub busy twice then success 0x200 -> 3 requests spaced IDLE cycles apart, rsp OK, data 0x200.
// - POLL 0x11 mask 0x200 expect 0x200 with allhalted set on the 4th read -> rsp OK, rsp_polls=4.
// - POLL with no match and POLL_TMO=16 -> exactly 16 reads, rsp TIMEOUT, rsp_data = last read.
// - Busy forever with MAX_RETRY=8 -> 9 requests then ERR_BUSY; failed op -> ERR_FAIL immediately.
// - Assert seq.rst in WAIT and with rsp_ready held low -> all outputs return to reset values next cycle,
//   and a new command is accepted.

Source files
------------

// File: rtl/adam_dmi_pkg.sv
// adam_dmi_pkg
// Shared types and constants for the DMI command engine and its users.
//   cmd_op_t      host command opcodes (NOP/READ/WRITE/POLL)
//   rsp_status_t  result status returned to the host
//   dmi_op_t      DMI request opcodes; DMI_RSP_* are the DMI response codes
//   DM_*          debug-module register addresses and commonly used bit indices
package adam_dmi_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_POLL  = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        RSP_OK       = 2'd0,
        RSP_ERR_FAIL = 2'd1,
        RSP_ERR_BUSY = 2'd2,
        RSP_TIMEOUT  = 2'd3
    } rsp_status_t;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2
    } dmi_op_t;

    // DMI response codes; 1 is reserved and handled as a failure
    localparam logic [1:0] DMI_RSP_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_RSP_FAILED  = 2'd2;
    localparam logic [1:0] DMI_RSP_BUSY    = 2'd3;

    localparam logic [6:0] DM_DMCONTROL = 7'h10;
    localparam logic [6:0] DM_DMSTATUS  = 7'h11;

    localparam int unsigned DMCONTROL_HALTREQ      = 31;
    localparam int unsigned DMCONTROL_RESUMEREQ    = 30;
    localparam int unsigned DMSTATUS_ALLHALTED     = 9;
    localparam int unsigned DMSTATUS_ALLRESUMEACK  = 17;

endpackage

// File: rtl/adam_dmi_cmd_engine.sv
// adam_dmi_cmd_engine
// Sequences one host command into DMI accesses toward the debug module: single
// read/write, or a poll loop that re-reads until (rd & mask) == (data & mask).
// Busy responses are retried up to MAX_RETRY times; IDLE idle cycles separate a
// DMI response from the next request. Exactly one DMI access is outstanding.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_*                        command channel (valid/ready, op/addr/data/mask)
//   rsp_*                        result channel (valid/ready, data/status/polls)
//   dmi_req_*                    DMI request channel toward the DM
//   dmi_rsp_*                    DMI response channel from the DM
module adam_dmi_cmd_engine
    import adam_dmi_pkg::*;
#(
    parameter int ABITS     = 7,
    parameter int DW        = 32,
    parameter int IDLE      = 1,
    parameter int MAX_RETRY = 8,
    parameter int POLL_TMO  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [ABITS-1:0]              cmd_addr,
    input  logic [DW-1:0]                 cmd_data,
    input  logic [DW-1:0]                 cmd_mask,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DW-1:0]                 rsp_data,
    output logic [1:0]                    rsp_status,
    output logic [$clog2(POLL_TMO+1)-1:0] rsp_polls,
    output logic                          dmi_req_valid,
    input  logic                          dmi_req_ready,
    output logic [ABITS-1:0]              dmi_req_addr,
    output logic [DW-1:0]                 dmi_req_data,
    output logic [1:0]                    dmi_req_op,
    input  logic                          dmi_rsp_valid,
    output logic                          dmi_rsp_ready,
    input  logic [DW-1:0]                 dmi_rsp_data,
    input  logic [1:0]                    dmi_rsp_op
);

    localparam int PW = $clog2(POLL_TMO + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int GW = (IDLE > 1) ? $clog2(IDLE) : 1;

    if (ABITS < 1 || POLL_TMO < 1) begin : g_param_check
        $error("adam_dmi_cmd_engine: ABITS and POLL_TMO must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_RESP
    } state_t;

    state_t             state_q,      state_d;
    cmd_op_t            op_q,         op_d;
    logic [ABITS-1:0]   addr_q,       addr_d;
    logic [DW-1:0]      data_q,       data_d;
    logic [DW-1:0]      mask_q,       mask_d;
    logic [RW-1:0]      retry_q,      retry_d;
    logic [PW-1:0]      polls_q,      polls_d;
    logic [GW-1:0]      gap_q,        gap_d;
    logic [DW-1:0]      rsp_data_q,   rsp_data_d;
    rsp_status_t        rsp_status_q, rsp_status_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= CMD_NOP;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            retry_q      <= '0;
            polls_q      <= '0;
            gap_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= RSP_OK;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            retry_q      <= retry_d;
            polls_q      <= polls_d;
            gap_q        <= gap_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        retry_d      = retry_q;
        polls_d      = polls_q;
        gap_d        = gap_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d         = cmd_op_t'(cmd_op);
                    addr_d       = cmd_addr;
                    data_d       = cmd_data;
                    mask_d       = cmd_mask;
                    retry_d      = '0;
                    polls_d      = '0;
                    gap_d        = '0;
                    rsp_data_d   = '0;
                    rsp_status_d = RSP_OK;
                    state_d      = (cmd_op_t'(cmd_op) == CMD_NOP) ? S_RESP : S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (dmi_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (dmi_rsp_valid) begin
                    // Every path either ends the command or schedules the next
                    // access, which goes through GAP unless IDLE is zero.
                    if (dmi_rsp_op == DMI_RSP_BUSY) begin
                        if (retry_q != RW'(MAX_RETRY + 1)) begin
                            retry_d = retry_q + RW'(1);
                        end
                        if (retry_d > RW'(MAX_RETRY)) begin
                            rsp_status_d = RSP_ERR_BUSY;
                            state_d      = S_RESP;
                        end else begin
                            gap_d   = '0;
                            state_d = (IDLE == 0) ? S_ISSUE : S_GAP;
                        end
                    end else if (dmi_rsp_op == DMI_RSP_SUCCESS) begin
                        if (op_q == CMD_POLL) begin
                            if (polls_q != PW'(POLL_TMO)) begin
                                polls_d = polls_q + PW'(1);
                            end
                            rsp_data_d = dmi_rsp_data;
                            if (((dmi_rsp_data ^ data_q) & mask_q) == '0) begin
                                rsp_status_d = RSP_OK;
                                state_d      = S_RESP;
                            end else if (polls_d == PW'(POLL_TMO)) begin
                                rsp_status_d = RSP_TIMEOUT;
                                state_d      = S_RESP;
                            end else begin
                                retry_d = '0;
                                gap_d   = '0;
                                state_d = (IDLE == 0) ? S_ISSUE : S_GAP;
                            end
                        end else begin
                            rsp_data_d   = (op_q == CMD_READ) ? dmi_rsp_data : '0;
                            rsp_status_d = RSP_OK;
                            state_d      = S_RESP;
                        end
                    end else begin
                        rsp_status_d = RSP_ERR_FAIL;
                        state_d      = S_RESP;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GW'(IDLE - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_data      = rsp_data_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_polls     = polls_q;
    assign dmi_req_valid = (state_q == S_ISSUE);
    assign dmi_req_addr  = addr_q;
    assign dmi_req_data  = (op_q == CMD_WRITE) ? data_q : '0;
    assign dmi_req_op    = (op_q == CMD_WRITE) ? DMI_OP_WRITE : DMI_OP_READ;
    assign dmi_rsp_ready = (state_q == S_WAIT);

    // A response with no access outstanding is a DM-side protocol error.
    a_rsp_only_in_wait : assert property (
        @(posedge clk) disable iff (rst) dmi_rsp_valid |-> (state_q == S_WAIT)
    );

endmodule

// File: tb/tb_adam_dmi_cmd_engine.sv
// tb_adam_dmi_cmd_engine
// Directed bench for adam_dmi_cmd_engine with a scripted DM responder.
module tb_adam_dmi_cmd_engine;
    import adam_dmi_pkg::*;

    localparam int ABITS     = 7;
    localparam int DW        = 32;
    localparam int IDLE      = 1;
    localparam int MAX_RETRY = 8;
    localparam int POLL_TMO  = 16;
    localparam int PW        = $clog2(POLL_TMO + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [ABITS-1:0] cmd_addr = '0;
    logic [DW-1:0]    cmd_data = '0;
    logic [DW-1:0]    cmd_mask = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [DW-1:0]    rsp_data;
    logic [1:0]       rsp_status;
    logic [PW-1:0]    rsp_polls;
    logic             dmi_req_valid;
    logic             dmi_req_ready = 1'b1;
    logic [ABITS-1:0] dmi_req_addr;
    logic [DW-1:0]    dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_rsp_valid = 1'b0;
    logic             dmi_rsp_ready;
    logic [DW-1:0]    dmi_rsp_data = '0;
    logic [1:0]       dmi_rsp_op = 2'd0;

    adam_dmi_cmd_engine #(
        .ABITS(ABITS), .DW(DW), .IDLE(IDLE), .MAX_RETRY(MAX_RETRY), .POLL_TMO(POLL_TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status), .rsp_polls(rsp_polls),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
        .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- DM stub ----------------
    // Requests are accepted immediately; one response is returned the cycle
    // after acceptance, taken from rsp_script or else the default response.
    logic [33:0]      rsp_script[$];
    logic [1:0]       dflt_op   = DMI_RSP_SUCCESS;
    logic [DW-1:0]    dflt_data = '0;
    bit               stub_hold = 1'b0;
    int unsigned      req_cnt   = 0;
    int unsigned      req_cyc[$];
    logic [ABITS-1:0] last_addr = '0;
    logic [1:0]       last_op   = '0;
    logic [DW-1:0]    last_wdata = '0;

    always @(negedge clk) begin
        logic [33:0] e;
        if (dmi_req_valid && dmi_req_ready && !rst) begin
            req_cnt++;
            req_cyc.push_back(cyc);
            last_addr  = dmi_req_addr;
            last_op    = dmi_req_op;
            last_wdata = dmi_req_data;
        end
        if (dmi_rsp_valid) begin
            dmi_rsp_valid = 1'b0;
        end else if (dmi_rsp_ready && !stub_hold && !rst) begin
            if (rsp_script.size() > 0) e = rsp_script.pop_front();
            else                       e = {dflt_op, dflt_data};
            dmi_rsp_op    = e[33:32];
            dmi_rsp_data  = e[31:0];
            dmi_rsp_valid = 1'b1;
        end
    end

    // ---------------- host tasks ----------------
    task automatic clear_log();
        req_cnt = 0;
        req_cyc.delete();
    endtask

    // Returns at the negedge right after the accepting clock edge.
    task automatic do_cmd(input logic [1:0] op, input logic [ABITS-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
        int unsigned n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid(input string tag);
        int unsigned n = 0;
        while (!rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic finish_rsp(input string tag, input logic [1:0] st,
                              input logic [DW-1:0] d, input logic [PW-1:0] p);
        wait_rsp_valid(tag);
        check({tag, "_status"}, 64'(rsp_status), 64'(st));
        check({tag, "_data"},   64'(rsp_data),   64'(d));
        check({tag, "_polls"},  64'(rsp_polls),  64'(p));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_dmi_rsp_ready();
        int unsigned n = 0;
        while (!dmi_rsp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!dmi_rsp_ready) check("wait_state_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready",     64'(cmd_ready),     64'd1);
        check("rst_rsp_valid",     64'(rsp_valid),     64'd0);
        check("rst_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rst_dmi_rsp_ready", 64'(dmi_rsp_ready), 64'd0);
        check("rst_rsp_data",      64'(rsp_data),      64'd0);
        check("rst_rsp_status",    64'(rsp_status),    64'd0);
        check("rst_rsp_polls",     64'(rsp_polls),     64'd0);

        // WRITE DMCONTROL = 1
        clear_log();
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h0});
        do_cmd(CMD_WRITE, DM_DMCONTROL, 32'h1, 32'h0);
        check("wr_issue_latency", 64'(dmi_req_valid), 64'd1);
        check("wr_req_op",        64'(dmi_req_op),    64'd2);
        check("wr_req_addr",      64'(dmi_req_addr),  64'h10);
        check("wr_req_data",      64'(dmi_req_data),  64'h1);
        finish_rsp("wr", RSP_OK, 32'h0, '0);
        check("wr_req_cnt", 64'(req_cnt), 64'd1);

        // READ DMSTATUS: busy, busy, success 0x200
        clear_log();
        rsp_script.push_back({DMI_RSP_BUSY, 32'h0});
        rsp_script.push_back({DMI_RSP_BUSY, 32'h0});
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h200});
        do_cmd(CMD_READ, DM_DMSTATUS, 32'h0, 32'h0);
        check("rd_req_op", 64'(dmi_req_op), 64'd1);
        finish_rsp("rd", RSP_OK, 32'h200, '0);
        check("rd_req_cnt", 64'(req_cnt), 64'd3);
        if (req_cyc.size() == 3) begin
            check("rd_spacing_1", 64'(req_cyc[1] - req_cyc[0]), 64'(IDLE + 2));
            check("rd_spacing_2", 64'(req_cyc[2] - req_cyc[1]), 64'(IDLE + 2));
        end
        check("rd_last_addr", 64'(last_addr), 64'h11);

        // POLL allhalted: match on 4th read (other bits must be masked off)
        clear_log();
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h0000_01FF});
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'hFFFF_FDFF});
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h0000_0000});
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h0000_0382});
        do_cmd(CMD_POLL, DM_DMSTATUS, 32'h200, 32'h200);
        finish_rsp("poll", RSP_OK, 32'h382, PW'(4));
        check("poll_req_cnt", 64'(req_cnt), 64'd4);

        // POLL never matches: 16 reads, data = last read
        clear_log();
        for (int i = 1; i <= POLL_TMO; i++) rsp_script.push_back({DMI_RSP_SUCCESS, 32'(i)});
        do_cmd(CMD_POLL, DM_DMSTATUS, 32'h200, 32'h200);
        finish_rsp("tmo", RSP_TIMEOUT, 32'h10, PW'(16));
        check("tmo_req_cnt", 64'(req_cnt), 64'd16);

        // Busy forever: 1 + MAX_RETRY requests
        clear_log();
        dflt_op = DMI_RSP_BUSY;
        do_cmd(CMD_READ, DM_DMSTATUS, 32'h0, 32'h0);
        finish_rsp("busy", RSP_ERR_BUSY, 32'h0, '0);
        check("busy_req_cnt", 64'(req_cnt), 64'd9);
        dflt_op = DMI_RSP_SUCCESS;

        // Failed, and reserved code 1 also failed
        clear_log();
        rsp_script.push_back({DMI_RSP_FAILED, 32'hDEAD});
        do_cmd(CMD_READ, DM_DMSTATUS, 32'h0, 32'h0);
        finish_rsp("fail", RSP_ERR_FAIL, 32'h0, '0);
        check("fail_req_cnt", 64'(req_cnt), 64'd1);
        clear_log();
        rsp_script.push_back({2'd1, 32'hBEEF});
        do_cmd(CMD_WRITE, DM_DMCONTROL, 32'h4, 32'h0);
        finish_rsp("rsvd", RSP_ERR_FAIL, 32'h0, '0);
        check("rsvd_req_cnt", 64'(req_cnt), 64'd1);

        // NOP: no DMI traffic
        clear_log();
        do_cmd(CMD_NOP, 7'h0, 32'h0, 32'h0);
        check("nop_no_req", 64'(dmi_req_valid), 64'd0);
        finish_rsp("nop", RSP_OK, 32'h0, '0);
        check("nop_req_cnt", 64'(req_cnt), 64'd0);

        // Reset while waiting for a DMI response
        stub_hold = 1'b1;
        do_cmd(CMD_READ, DM_DMSTATUS, 32'h0, 32'h0);
        wait_dmi_rsp_ready();
        rst = 1'b1;
        @(negedge clk);
        check("rstw_cmd_ready",     64'(cmd_ready),     64'd1);
        check("rstw_dmi_rsp_ready", 64'(dmi_rsp_ready), 64'd0);
        check("rstw_dmi_req_valid", 64'(dmi_req_valid), 64'd0);
        check("rstw_rsp_valid",     64'(rsp_valid),     64'd0);
        rst = 1'b0;
        stub_hold = 1'b0;

        // Reset while a result is pending and rsp_ready is low
        rsp_script.delete();
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h77});
        do_cmd(CMD_READ, DM_DMSTATUS, 32'h0, 32'h0);
        wait_rsp_valid("rstr");
        repeat (2) @(negedge clk);
        check("rstr_hold_valid", 64'(rsp_valid), 64'd1);
        check("rstr_hold_data",  64'(rsp_data),  64'h77);
        rst = 1'b1;
        @(negedge clk);
        check("rstr_rsp_valid",  64'(rsp_valid),  64'd0);
        check("rstr_rsp_data",   64'(rsp_data),   64'd0);
        check("rstr_rsp_status", 64'(rsp_status), 64'd0);
        check("rstr_cmd_ready",  64'(cmd_ready),  64'd1);
        rst = 1'b0;

        // New command after reset (haltreq write)
        clear_log();
        rsp_script.push_back({DMI_RSP_SUCCESS, 32'h0});
        do_cmd(CMD_WRITE, DM_DMCONTROL, 32'h8000_0000, 32'h0);
        finish_rsp("post", RSP_OK, 32'h0, '0);
        check("post_req_cnt",   64'(req_cnt),    64'd1);
        check("post_req_wdata", 64'(last_wdata), 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit reached");
    end

endmodule
